// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART blocks (transmitter now, a
// receiver later): FSM state encoding, parity-mode constants, and helpers for
// bit timing and parity generation.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Frame sequencing states; binary encoded.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

    // Parity modes.
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clock cycles per bit, truncated toward zero.
    function automatic int calc_cpb(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Parity bit for up to 9 data bits (unused upper bits must be zero).
    // Even mode yields the XOR of the data; odd mode its inverse.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..CPB-1 continuously; i_restart forces the count
// back to 0 so a new bit period begins in the cycle after the restart edge.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_restart    restart the bit period from count 0
//   o_tick       registered; high during the last cycle of each bit period
//   o_tick_next  look-ahead; high when o_tick will be high in the next cycle
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CPB = 868
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick,
    output logic o_tick_next
);

    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;

    // Next count: restart or wrap to zero, otherwise increment.
    always_comb begin
        cnt_d = cnt_q;
        if (i_restart) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(CPB - 1)) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign o_tick_next = (cnt_d == CNT_W'(CPB - 1));

    // Counter and registered end-of-bit flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= {CNT_W{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= o_tick_next;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// Parameterised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional even/odd parity bit, STOP_BITS stop bits. Valid/ready handshake;
// a frame may be accepted in the final stop cycle for gap-free streaming.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset (aborts any frame in flight)
//   i_valid  a frame is offered on i_data
//   o_ready  frame can be accepted this cycle (idle, or last stop cycle)
//   i_data   frame payload, captured on the accepting edge
//   o_tx     serial line, idle high
//   o_busy   a frame is being shifted out
// -----------------------------------------------------------------------------
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam int CPB   = calc_cpb(CLK_FREQ, BAUD_RATE);
    localparam int BIT_W = $clog2(DATA_BITS);

    // Reject illegal configurations at elaboration.
    generate
        if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS must be 5..9");
        end
        if ((PARITY != PAR_NONE) && (PARITY != PAR_EVEN) && (PARITY != PAR_ODD)) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
        if (CPB < 2) begin : g_bad_cpb
            $error("uart_tx_cfg: CLK_FREQ / BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_state_e          state_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 ready_q;
    logic                 par_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;

    logic accept_s;
    logic tick_s;
    logic tick_next_s;
    logic last_stop_s;

    assign accept_s    = i_valid && ready_q;
    assign last_stop_s = (stop_cnt_q == 1'(STOP_BITS - 1));

    // Bit timing restarts on every accept so the start bit lines up with it.
    uart_baud_gen #(
        .CPB (CPB)
    ) u_baud (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_restart   (accept_s),
        .o_tick      (tick_s),
        .o_tick_next (tick_next_s)
    );

    // Frame sequencer; all outputs come straight from these registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            par_q      <= 1'b0;
            shift_q    <= {DATA_BITS{1'b0}};
            bit_cnt_q  <= {BIT_W{1'b0}};
            stop_cnt_q <= 1'b0;
        end else if (accept_s) begin
            // Only reachable from IDLE or the final stop cycle.
            state_q    <= ST_START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            par_q      <= parity_bit(9'(i_data), PARITY);
            shift_q    <= i_data;
            bit_cnt_q  <= {BIT_W{1'b0}};
            stop_cnt_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                ST_START: begin
                    if (tick_s) begin
                        state_q   <= ST_DATA;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= {BIT_W{1'b0}};
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                            if (PARITY != PAR_NONE) begin
                                state_q <= ST_PAR;
                                tx_q    <= par_q;
                            end else begin
                                state_q    <= ST_STOP;
                                tx_q       <= 1'b1;
                                stop_cnt_q <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
                ST_PAR: begin
                    if (tick_s) begin
                        state_q    <= ST_STOP;
                        tx_q       <= 1'b1;
                        stop_cnt_q <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        if (last_stop_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                            ready_q    <= 1'b0;
                        end
                    end else begin
                        // Raise ready one edge early so it is high exactly in
                        // the final cycle of the last stop bit.
                        ready_q <= last_stop_s && tick_next_s;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx    = tx_q;
    assign o_busy  = busy_q;
    assign o_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
// Four transmitter configurations share one clock, reset and stimulus bus;
// sel routes the handshake to one of them. Each frame is checked cycle by
// cycle against a line waveform computed from the frame format.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [8:0] data;
    int         sel;

    logic [3:0] rdy_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic       rdy_m;
    logic       tx_m;
    logic       busy_m;

    int vectors = 0;
    int fails   = 0;

    // Per-configuration frame format: cycles/bit, data bits, parity, stops.
    int cpb_t   [4] = '{868, 16, 3, 2};
    int dbits_t [4] = '{8, 8, 7, 9};
    int par_t   [4] = '{0, 1, 0, 2};
    int stop_t  [4] = '{1, 1, 2, 1};

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_FREQ(100_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.i_clk(clk), .i_rst(rst), .i_valid(valid && (sel == 0)), .o_ready(rdy_v[0]),
           .i_data(data[7:0]), .o_tx(tx_v[0]), .o_busy(busy_v[0]));

    uart_tx_cfg #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    dut_b (.i_clk(clk), .i_rst(rst), .i_valid(valid && (sel == 1)), .o_ready(rdy_v[1]),
           .i_data(data[7:0]), .o_tx(tx_v[1]), .o_busy(busy_v[1]));

    uart_tx_cfg #(.CLK_FREQ(100), .BAUD_RATE(33), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    dut_c (.i_clk(clk), .i_rst(rst), .i_valid(valid && (sel == 2)), .o_ready(rdy_v[2]),
           .i_data(data[6:0]), .o_tx(tx_v[2]), .o_busy(busy_v[2]));

    uart_tx_cfg #(.CLK_FREQ(20), .BAUD_RATE(10), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1))
    dut_d (.i_clk(clk), .i_rst(rst), .i_valid(valid && (sel == 3)), .o_ready(rdy_v[3]),
           .i_data(data), .o_tx(tx_v[3]), .o_busy(busy_v[3]));

    assign rdy_m  = rdy_v[sel[1:0]];
    assign tx_m   = tx_v[sel[1:0]];
    assign busy_m = busy_v[sel[1:0]];

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (cfg %0d): observed %b expected %b", tag, sel, obs, exp);
        end
    endtask

    function automatic int frame_len(input int s);
        return cpb_t[s] * (1 + dbits_t[s] + ((par_t[s] != 0) ? 1 : 0) + stop_t[s]);
    endfunction

    // Expected line level in cycle k (k = 1 is the cycle after the accept edge).
    function automatic logic line_level(input int s, input logic [8:0] dm, input int k);
        int idx;
        int ones;
        idx  = (k - 1) / cpb_t[s];
        ones = $countones(dm);
        if (idx == 0) return 1'b0;
        if (idx <= dbits_t[s]) return dm[idx-1];
        if ((par_t[s] != 0) && (idx == dbits_t[s] + 1))
            return (par_t[s] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
        return 1'b1;
    endfunction

    // Wait (bounded) for ready, then present a frame.
    task automatic offer(input logic [8:0] d);
        int n = 0;
        while ((rdy_m !== 1'b1) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        chk("offer_ready", rdy_m, 1'b1);
        valid = 1'b1;
        data  = d;
    endtask

    // Follow one frame accepted at the next rising edge. noise: scramble
    // i_valid/i_data while ready is low. chain: offer next_d in the last
    // stop cycle. abort_at: pulse reset in that cycle (0 = never).
    task automatic run_frame(input logic [8:0] d, input bit noise, input bit chain,
                             input logic [8:0] next_d, input int abort_at);
        int         n;
        logic [8:0] dm;
        n  = frame_len(sel);
        dm = d & 9'((1 << dbits_t[sel]) - 1);
        @(negedge clk);
        for (int k = 1; k <= n; k++) begin
            chk("tx", tx_m, line_level(sel, dm, k));
            chk("busy", busy_m, 1'b1);
            chk("ready", rdy_m, k == n);
            if (k == abort_at) begin
                rst   = 1'b1;
                valid = 1'b1;
                data  = 9'h1AA;
                @(negedge clk);
                chk("abort_tx", tx_m, 1'b1);
                chk("abort_busy", busy_m, 1'b0);
                chk("abort_ready", rdy_m, 1'b0);
                rst   = 1'b0;
                valid = 1'b0;
                @(negedge clk);
                chk("abort_ready_rise", rdy_m, 1'b1);
                chk("abort_tx_idle", tx_m, 1'b1);
                chk("abort_busy_idle", busy_m, 1'b0);
                return;
            end
            if (k < n) begin
                if (noise) begin
                    valid = 1'($urandom_range(0, 1));
                    data  = 9'($urandom);
                end
                @(negedge clk);
            end else if (chain) begin
                valid = 1'b1;
                data  = next_d;
            end else begin
                valid = 1'b0;
            end
        end
        if (!chain) begin
            repeat (2) begin
                @(negedge clk);
                chk("idle_tx", tx_m, 1'b1);
                chk("idle_busy", busy_m, 1'b0);
                chk("idle_ready", rdy_m, 1'b1);
            end
        end
    endtask

    // Random frames on the current configuration, some chained back to back.
    task automatic random_frames(input int count);
        logic [8:0] cur;
        logic [8:0] nxt;
        bit         ch;
        cur = 9'($urandom);
        offer(cur);
        for (int i = 0; i < count; i++) begin
            nxt = 9'($urandom);
            ch  = (i < count - 1) && ($urandom_range(0, 1) == 1);
            run_frame(cur, (i == 2), ch, nxt, 0);
            if (!ch && (i < count - 1)) offer(nxt);
            cur = nxt;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel   = 0;
        rst   = 1'b1;
        valid = 1'b1;
        data  = 9'h155;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            chk("rst_tx", tx_v[s], 1'b1);
            chk("rst_busy", busy_v[s], 1'b0);
            chk("rst_ready", rdy_v[s], 1'b0);
        end
        // Release reset with valid still high: the stale request is ignored.
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            chk("rel_ready", rdy_v[s], 1'b1);
            chk("rel_busy", busy_v[s], 1'b0);
            chk("rel_tx", tx_v[s], 1'b1);
        end
        valid = 1'b0;
        @(negedge clk);

        // 8N1 at 868 cycles per bit.
        offer(9'h055);
        run_frame(9'h055, 1'b0, 1'b0, 9'h000, 0);
        offer(9'h0A5);
        run_frame(9'h0A5, 1'b0, 1'b1, 9'h03C, 0);
        run_frame(9'h03C, 1'b0, 1'b0, 9'h000, 0);
        offer(9'h0FF);
        run_frame(9'h0FF, 1'b0, 1'b0, 9'h000, 5 * 868 + 434);
        offer(9'h081);
        run_frame(9'h081, 1'b0, 1'b0, 9'h000, 0);
        offer(9'h0C3);
        run_frame(9'h0C3, 1'b1, 1'b0, 9'h000, 0);

        // 8E1, 16 cycles per bit.
        sel = 1;
        @(negedge clk);
        offer(9'h007);
        run_frame(9'h007, 1'b0, 1'b0, 9'h000, 0);
        random_frames(8);

        // 7N2, 3 cycles per bit (100 / 33 truncated).
        sel = 2;
        @(negedge clk);
        offer(9'h07F);
        run_frame(9'h07F, 1'b0, 1'b0, 9'h000, 0);
        random_frames(8);

        // 9O1 at the minimum of 2 cycles per bit.
        sel = 3;
        @(negedge clk);
        offer(9'h007);
        run_frame(9'h007, 1'b0, 1'b0, 9'h000, 0);
        offer(9'h1FF);
        run_frame(9'h1FF, 1'b0, 1'b0, 9'h000, 3);
        random_frames(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLK_FREQ, 100_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, 115200, line rate in bit/s.
REQ-003 Parameter DATA_BITS, 8, data bits per frame; legal 5..9.
REQ-004 Parameter PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, 1, stop bits per frame; legal 1..2.
REQ-006 Port i_clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-007 Port i_rst  input  1  reset; synchronous and active-high.
REQ-008 Port i_valid  input  1  a frame is offered on i_data.
REQ-009 Port o_ready  output  1  the block can accept a frame this cycle.
REQ-010 Port i_data  input  DATA_BITS  frame payload, sampled at accept.
REQ-011 Port o_tx  output  1  serial line, idle high.
REQ-012 Port o_busy  output  1  a frame is being shifted out.

Function
REQ-013 CPB = CLK_FREQ / BAUD_RATE, integer-truncated; every bit SHALL last exactly CPB cycles.
REQ-014 Out-of-range DATA_BITS, PARITY or STOP_BITS, or CPB < 2, SHALL cause an elaboration error.
REQ-015 Accept occurs on a rising edge where i_valid && o_ready; i_data SHALL be captured into a shift register on that edge.
REQ-016 FSM states: IDLE, START, DATA, PAR, STOP; registered, one-hot or binary at implementer's choice.
REQ-017 IDLE -> START on accept; o_tx SHALL go low on the edge of accept (1-cycle latency from the accepting edge).
REQ-018 START -> DATA after CPB cycles; DATA SHALL send DATA_BITS bits LSB first, then go to PAR if PARITY != 0, else to STOP.
REQ-019 PAR bit SHALL be XOR of the captured data for even parity and its inverse for odd parity; duration CPB.
REQ-020 STOP SHALL drive o_tx high for STOP_BITS*CPB cycles, then go to IDLE.
REQ-021 o_ready SHALL be high in IDLE and in the final cycle of the last stop bit, and low otherwise.
REQ-022 Accept in the final stop cycle SHALL go directly to START with no idle gap (back-to-back frames).
REQ-023 o_busy SHALL be high in every state except IDLE, and SHALL stay high across back-to-back frames.
REQ-024 The baud counter SHALL restart from 0 on accept, so the start-bit edge aligns with the accept edge.
REQ-025 i_valid and i_data changes while o_ready is low SHALL NOT affect the frame in flight.
REQ-026 The bit counter width is clog2(DATA_BITS); the baud counter width is clog2(CPB).

Reset
REQ-027 While i_rst is high at a rising edge: state = IDLE, o_tx = 1, o_busy = 0, o_ready = 0, counters = 0.
REQ-028 Reset mid-frame SHALL abort the frame; o_tx SHALL be high from the next edge.
REQ-029 o_ready SHALL rise in the first cycle after the edge where i_rst is sampled low.
REQ-030 i_valid asserted during reset SHALL be ignored.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state typedef, the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and a CPB computation function, for shared use with a future uart_rx_cfg.
REQ-032 Sub-module uart_baud_gen (parameter CPB; inputs i_clk, i_rst, i_restart; output o_tick at the last cycle of each bit) SHALL generate bit timing.
REQ-033 All outputs SHALL be driven directly from registers.

Verification (CLK_FREQ=100_000_000, BAUD_RATE=115200, CPB=868)
REQ-034 8N1, send 0x55 -> o_tx = 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each 868 cycles; frame 8680 cycles; o_ready low 8679 cycles.
REQ-035 PARITY=1, send 0x07 -> parity bit 1; PARITY=2, send 0x07 -> parity bit 0; frame 9548 cycles.
REQ-036 DATA_BITS=7, STOP_BITS=2, send 0x7F -> 1 start, 7 ones, 2 stop bits; o_tx high for 1736 cycles before IDLE.
REQ-037 i_valid held high, 0xA5 then 0x3C -> second start falling edge exactly 8680 cycles after the first; o_busy never drops between frames.
REQ-038 i_rst pulsed for 1 cycle during data bit 4 of 0xFF -> o_tx = 1 and o_busy = 0 on the next edge; o_ready = 1 one cycle later; next frame 0x81 is correct.
REQ-039 i_data toggled and i_valid pulsed mid-frame -> the frame in flight is unchanged and no extra frame is sent.
